// File: rtl/probe_capture.sv
// rtl/probe_capture.sv - ring-buffer capture engine for debug probe buses
//
// Samples a packed probe bus into a DEPTH-entry ring buffer, evaluates a
// runtime trigger (level / rising edge / any change / force) with a
// programmable pre-trigger depth, freezes DEPTH samples around the trigger
// and streams them out oldest-first over a valid/ready port.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   probe, sample_en      probe sample and its qualifier
//   arm, abort            start a capture (IDLE/DONE only) / return to IDLE
//   trig_mode/mask/value  trigger configuration, latched on arm
//   pre_trig              samples kept before the trigger sample
//   rd_start              begin readout (DONE only)
//   rd_ready, rd_valid,
//   rd_data, rd_last      readout stream
//   state                 0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE, 5 READ
//   triggered, trig_addr  trigger seen / buffer address of trigger sample
//
// DEPTH must be a power of two and at least 4 so that pointers wrap
// naturally in ADDR_W bits.
module probe_capture #(
  parameter int PROBE_W = 64,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe,
  input  logic               sample_en,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [ADDR_W-1:0]  pre_trig,
  input  logic               rd_start,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [PROBE_W-1:0] rd_data,
  output logic               rd_last,
  output logic [2:0]         state,
  output logic               triggered,
  output logic [ADDR_W-1:0]  trig_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4,
    S_READ = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t st, st_nxt;

  // configuration latched on arm
  logic [1:0]         mode_q;
  logic [PROBE_W-1:0] mask_q;
  logic [PROBE_W-1:0] value_q;
  logic [ADDR_W-1:0]  pre_q;

  // capture side
  logic [PROBE_W-1:0] prev_q;
  logic               hist_valid;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  cnt;        // pre-trigger countdown, then post-trigger countdown
  logic [ADDR_W-1:0]  post_len;

  // readout side: stage 1 is the RAM output, stage 2 the output register
  logic [PROBE_W-1:0] mem [DEPTH];
  logic [PROBE_W-1:0] mem_q;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  rd_cnt;
  logic               issue_done;
  logic               s1_valid;
  logic               s1_last;

  logic arm_ok, start_ok, wr_en, cond, hit, out_free, rd_en;

  assign state    = st;
  assign post_len = LAST_IDX - pre_q;

  always_comb begin
    arm_ok   = arm && (st == S_IDLE || st == S_DONE);
    start_ok = rd_start && !arm && (st == S_DONE);
    wr_en    = sample_en && (st == S_PRE || st == S_WAIT || st == S_POST);

    case (mode_q)
      2'd0:    cond = ((probe ^ value_q) & mask_q) == '0;
      2'd1:    cond = hist_valid && (|(~prev_q & probe & mask_q));
      2'd2:    cond = hist_valid && (|((prev_q ^ probe) & mask_q));
      default: cond = 1'b1;
    endcase
    hit = wr_en && (st == S_WAIT) && cond;

    // the output register may take a new beat when empty or being drained;
    // the RAM read is enabled only then so stage 1 holds during a stall
    out_free = !rd_valid || rd_ready;
    rd_en    = (st == S_READ) && !issue_done && out_free;

    st_nxt = st;
    if (abort) begin
      st_nxt = S_IDLE;
    end else begin
      case (st)
        S_IDLE: if (arm) st_nxt = (pre_trig == '0) ? S_WAIT : S_PRE;
        S_PRE:  if (wr_en && cnt == ONE) st_nxt = S_WAIT;
        S_WAIT: if (hit) st_nxt = (post_len == '0) ? S_DONE : S_POST;
        S_POST: if (wr_en && cnt == ONE) st_nxt = S_DONE;
        S_DONE: begin
          if (arm)           st_nxt = (pre_trig == '0) ? S_WAIT : S_PRE;
          else if (rd_start) st_nxt = S_READ;
        end
        S_READ: if (rd_valid && rd_ready && rd_last) st_nxt = S_DONE;
        default: st_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      pre_q      <= '0;
      prev_q     <= '0;
      hist_valid <= 1'b0;
      wr_ptr     <= '0;
      cnt        <= '0;
      triggered  <= 1'b0;
      trig_addr  <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      issue_done <= 1'b0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
    end else if (abort) begin
      triggered <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      if (arm_ok) begin
        mode_q     <= trig_mode;
        mask_q     <= trig_mask;
        value_q    <= trig_value;
        pre_q      <= pre_trig;
        wr_ptr     <= '0;
        cnt        <= pre_trig;
        triggered  <= 1'b0;
        hist_valid <= 1'b0;
      end else if (wr_en) begin
        wr_ptr     <= wr_ptr + ONE;
        prev_q     <= probe;
        hist_valid <= 1'b1;
        if (st == S_PRE || st == S_POST) cnt <= cnt - ONE;
        if (hit) begin
          triggered <= 1'b1;
          trig_addr <= wr_ptr;
          cnt       <= post_len;
        end
      end

      // after a complete capture wr_ptr points at the oldest sample
      if (start_ok) begin
        rd_ptr     <= wr_ptr;
        rd_cnt     <= '0;
        issue_done <= 1'b0;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
        rd_cnt <= rd_cnt + ONE;
        if (rd_cnt == LAST_IDX) issue_done <= 1'b1;
      end

      if (out_free) begin
        s1_valid <= rd_en;
        s1_last  <= rd_en && (rd_cnt == LAST_IDX);
        rd_valid <= s1_valid;
        rd_last  <= s1_last;
        if (s1_valid) rd_data <= mem_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= probe;
    if (rd_en) mem_q <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_probe_capture.sv
// tb/tb_probe_capture.sv - self-checking bench for probe_capture
module tb_probe_capture;

  localparam int PW = 16;
  localparam int DP = 16;
  localparam int AW = 4;

  localparam int S_IDLE = 0, S_PRE = 1, S_WAIT = 2, S_POST = 3, S_DONE = 4, S_READ = 5;

  logic          clk, rst_n;
  logic [PW-1:0] probe;
  logic          sample_en, arm, abort;
  logic [1:0]    trig_mode;
  logic [PW-1:0] trig_mask, trig_value;
  logic [AW-1:0] pre_trig;
  logic          rd_start, rd_ready;
  logic          rd_valid, rd_last, triggered;
  logic [PW-1:0] rd_data;
  logic [2:0]    state;
  logic [AW-1:0] trig_addr;

  probe_capture #(.PROBE_W(PW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .probe(probe), .sample_en(sample_en),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_mask(trig_mask),
    .trig_value(trig_value), .pre_trig(pre_trig), .rd_start(rd_start),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .state(state), .triggered(triggered), .trig_addr(trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_state = S_IDLE;
  int            m_pre, m_mode;
  logic [PW-1:0] m_mask, m_value;
  logic [PW-1:0] s[$];        // every accepted sample since arm, in order
  logic [PW-1:0] win[$];      // expected readout window
  bit            m_trig = 0;
  int            m_tidx;
  bit            rd_active = 0;
  int            rd_cyc, rd_k;

  function automatic bit m_cond(input int n, input logic [PW-1:0] pv);
    logic [PW-1:0] prev;
    prev = (n > 0) ? s[n-1] : '0;
    case (m_mode)
      0:       return ((pv ^ m_value) & m_mask) == '0;
      1:       return (n > 0) && (|(~prev & pv & m_mask));
      2:       return (n > 0) && (|((prev ^ pv) & m_mask));
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = S_IDLE; m_trig = 0; rd_active = 0; s.delete();
    end else if (abort) begin
      m_state = S_IDLE; m_trig = 0; rd_active = 0;
    end else begin
      case (m_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            m_pre = int'(pre_trig); m_mode = int'(trig_mode);
            m_mask = trig_mask; m_value = trig_value;
            s.delete(); m_trig = 0;
            m_state = (m_pre == 0) ? S_WAIT : S_PRE;
          end else if (m_state == S_DONE && rd_start) begin
            win.delete();
            for (int k = 0; k < DP; k++) win.push_back(s[m_tidx - m_pre + k]);
            m_state = S_READ; rd_active = 1; rd_cyc = 0; rd_k = 0;
          end
        end
        S_PRE, S_WAIT, S_POST: begin
          if (sample_en) begin
            int n;
            n = s.size();
            if (!m_trig && n >= m_pre && m_cond(n, probe)) begin
              m_trig = 1; m_tidx = n;
            end
            s.push_back(probe);
            if (!m_trig) m_state = (n + 1 < m_pre) ? S_PRE : S_WAIT;
            else if (n + 1 == m_tidx - m_pre + DP) m_state = S_DONE;
            else m_state = S_POST;
          end
        end
        S_READ: begin
          rd_cyc++;
          if (rd_valid && rd_ready) begin
            rd_k++;
            if (rd_k == DP) begin m_state = S_DONE; rd_active = 0; end
          end
        end
        default: m_state = S_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [PW-1:0] got[$];
  bit prev_valid = 0, prev_ready = 0, ready_always = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state, m_state);
      chk("triggered", triggered, m_trig);
      if (m_trig) chk("trig_addr", trig_addr, m_tidx % DP);
      if (!rd_valid) chk("rd_last_idle", rd_last, 0);
      if (!rd_active) begin
        chk("rd_valid_idle", rd_valid, 0);
      end else begin
        if (!rd_ready) ready_always = 0;
        if (rd_cyc < 2) chk("rd_valid_latency", rd_valid, 0);
        else if (rd_cyc == 2) chk("rd_valid_first", rd_valid, 1);
        else if (!rd_valid) begin
          if (prev_valid && !prev_ready) chk("rd_valid_held", rd_valid, 1);
          if (ready_always) chk("rd_no_bubble", rd_valid, 1);
        end
        if (rd_valid && rd_k < DP) begin
          chk("rd_data", rd_data, win[rd_k]);
          chk("rd_last", rd_last, (rd_k == DP - 1));
          if (rd_ready) got.push_back(rd_data);
        end
      end
      prev_valid = rd_valid;
      prev_ready = rd_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [PW-1:0] pat_val(input int pat, input int idx);
    case (pat)
      0:       return PW'(idx);
      1:       return (idx == 20) ? 16'd3 : PW'(idx);
      2:       return {15'(idx), ((idx >= 7 && idx <= 9) ? 1'b0 : 1'b1)};
      default: return PW'($urandom);
    endcase
  endfunction

  // en_style: 0 always, 1 every other cycle, 2 random (with arm/rd_start noise)
  task automatic capture(input int pat, input int pre, input int mode,
                         input logic [PW-1:0] mask, input logic [PW-1:0] value,
                         input int en_style, input bit do_abort, input bit with_rd);
    int cyc, idx, post_cyc;
    bit en;
    pre_trig = AW'(pre); trig_mode = 2'(mode); trig_mask = mask; trig_value = value;
    arm = 1; rd_start = with_rd; sample_en = 0;
    step();
    arm = 0; rd_start = 0;
    if (with_rd) chk("arm_beats_rd_start", state, (pre == 0) ? S_WAIT : S_PRE);
    trig_mode = 2'($urandom); trig_mask = PW'($urandom);
    trig_value = PW'($urandom); pre_trig = AW'($urandom);
    cyc = 0; idx = 0; post_cyc = 0;
    while (m_state != S_DONE && cyc < 3000) begin
      case (en_style)
        0:       en = 1;
        1:       en = cyc[0];
        default: en = 1'($urandom);
      endcase
      sample_en = en;
      probe = en ? pat_val(pat, idx) : PW'($urandom);
      if (en) idx++;
      if (en_style == 2) begin
        arm = ($urandom_range(0, 9) == 0);
        rd_start = ($urandom_range(0, 9) == 0);
      end
      step();
      arm = 0; rd_start = 0;
      cyc++;
      if (do_abort && m_state == S_POST) begin
        post_cyc++;
        if (post_cyc == 3) begin
          abort = 1; sample_en = 1;
          step();
          abort = 0; sample_en = 0;
          chk("abort_state", state, S_IDLE);
          chk("abort_triggered", triggered, 0);
          return;
        end
      end
    end
    sample_en = 0;
    chk("capture_timeout", (cyc < 3000), 1);
  endtask

  // rdy_style: 0 always ready, 1 toggle 1,0,1,0, 2 random
  task automatic readout(input int rdy_style);
    int n;
    got.delete();
    ready_always = 1;
    rd_ready = (rdy_style != 2) ? 1'b1 : 1'($urandom);
    rd_start = 1;
    step();
    rd_start = 0;
    n = 0;
    while (rd_active && n < 400) begin
      case (rdy_style)
        0:       rd_ready = 1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom);
      endcase
      step();
      n++;
    end
    rd_ready = 0;
    chk("readout_timeout", (n < 400), 1);
    chk("readout_beats", got.size(), DP);
  endtask

  initial begin
    rst_n = 0; probe = '0; sample_en = 0; arm = 0; abort = 0;
    trig_mode = '0; trig_mask = '0; trig_value = '0; pre_trig = '0;
    rd_start = 0; rd_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_state", state, S_IDLE);
    chk("reset_triggered", triggered, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_last", rd_last, 0);
    chk("reset_trig_addr", trig_addr, 0);
    chk("reset_rd_data", rd_data, 0);
    chk_en = 1;

    // 1: level match on 42, pre 4
    capture(0, 4, 0, 16'hFFFF, 16'd42, 0, 0, 0);
    chk("s1_tidx", m_tidx, 42);
    chk("s1_trig_addr", trig_addr, 10);
    readout(0);
    chk("s1_first", got[0], 38);
    chk("s1_last", got[15], 53);
    // 4: repeated readout with toggling ready
    readout(1);
    chk("s4_first", got[0], 38);
    chk("s4_last", got[15], 53);

    // 2: early match ignored in PRE
    capture(1, 8, 0, 16'hFFFF, 16'd3, 0, 0, 0);
    chk("s2_trig_addr", trig_addr, 4);
    readout(0);
    chk("s2_first", got[0], 12);
    chk("s2_last", got[15], 27);

    // 3: rising edge, no trigger on first sample
    capture(2, 0, 1, 16'h0001, 16'h0000, 0, 0, 0);
    chk("s3_tidx", m_tidx, 10);
    chk("s3_trig_addr", trig_addr, 10);
    readout(2);

    // 5: gapped sample_en, abort mid-POST, then re-arm
    capture(0, 4, 0, 16'hFFFF, 16'd42, 1, 0, 0);
    readout(0);
    chk("s5_first", got[0], 38);
    capture(0, 4, 0, 16'hFFFF, 16'd42, 1, 1, 0);
    capture(0, 4, 0, 16'hFFFF, 16'd42, 0, 0, 0);
    readout(1);
    chk("s5_rearm_last", got[15], 53);

    // 6: force trigger, then arm together with rd_start
    capture(0, 0, 3, 16'h0000, 16'h0000, 0, 0, 0);
    chk("s6_trig_addr", trig_addr, 0);
    readout(0);
    chk("s6_first", got[0], 0);
    chk("s6_last", got[15], 15);
    capture(0, 0, 3, 16'h0000, 16'h0000, 0, 0, 1);
    readout(0);

    // randomized captures
    for (int r = 0; r < 12; r++) begin
      int mode;
      logic [PW-1:0] mask;
      mode = $urandom_range(0, 3);
      if (mode == 0) mask = PW'($urandom) & 16'h000F;
      else mask = (16'h1 << $urandom_range(0, 15)) | (PW'($urandom) & 16'h00F0);
      capture(3, $urandom_range(0, DP - 1), mode, mask, PW'($urandom), 2, (r % 5 == 4), 0);
      if (m_state == S_DONE) readout($urandom_range(0, 2));
    end

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
